multicycle_ctrl: RTL and testbench

Moore-style control unit for the multicycle MIPS datapath. It sequences one instruction at a time through fetch, decode, execute, memory and writeback states. It drives every datapath select and enable, including the ALU B-operand mux selector (`alu_src_b`), the A-operand select, the ALU operation and the PC source. It sits beside the register/ALU datapath and receives the fetched instruction's opcode/funct and the ALU zero flag.

---
 rtl/ctrl_pkg.sv | 61 ++++++
 rtl/multicycle_ctrl.sv | 179 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multicycle MIPS control unit and its datapath muxes
package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RESET     = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_R_EXEC    = 4'd3,
        ST_R_WB      = 4'd4,
        ST_ADDR      = 4'd5,
        ST_ADDI_EXEC = 4'd6,
        ST_ADDI_WB   = 4'd7,
        ST_MEM_RD    = 4'd8,
        ST_LW_WB     = 4'd9,
        ST_MEM_WR    = 4'd10,
        ST_BRANCH    = 4'd11,
        ST_JUMP      = 4'd12,
        ST_ILLEGAL   = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_XOR = 6'h26;

    localparam logic [2:0] ALU_PASS_A = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b001;
    localparam logic [2:0] ALU_SUB    = 3'b010;
    localparam logic [2:0] ALU_AND    = 3'b011;
    localparam logic [2:0] ALU_XOR    = 3'b110;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic funct_legal(input logic [5:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) || (f == FN_XOR);
    endfunction

    function automatic logic [2:0] funct_alu_op(input logic [5:0] f);
        case (f)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_XOR:  return ALU_XOR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore control FSM sequencing the multicycle MIPS datapath
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mdr_load,
    output logic       a_load,
    output logic       b_load,
    output logic       alu_out_load,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    state_e     state_q, state_d;
    logic [2:0] wait_q, wait_d;
    logic [2:0] r_op_q, r_op_d;
    logic       is_store_q, is_store_d;
    logic       wait_done;

    assign wait_done = (wait_q == WAIT_LAST);

    // State register, wait counter and the instruction facts captured in DECODE
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RESET;
            wait_q     <= 3'd0;
            r_op_q     <= ALU_ADD;
            is_store_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            r_op_q     <= r_op_d;
            is_store_q <= is_store_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        r_op_d     = r_op_q;
        is_store_d = is_store_q;
        case (state_q)
            ST_RESET:  state_d = ST_FETCH;
            ST_FETCH:  if (wait_done) state_d = ST_DECODE;
            ST_DECODE: begin
                r_op_d     = funct_alu_op(funct);
                is_store_d = (opcode == OP_SW);
                case (opcode)
                    OP_RTYPE: state_d = funct_legal(funct) ? ST_R_EXEC : ST_ILLEGAL;
                    OP_ADDI:  state_d = ST_ADDI_EXEC;
                    OP_LW,
                    OP_SW:    state_d = ST_ADDR;
                    OP_BEQ:   state_d = ST_BRANCH;
                    OP_J:     state_d = ST_JUMP;
                    default:  state_d = ST_ILLEGAL;
                endcase
            end
            ST_R_EXEC:    state_d = ST_R_WB;
            ST_ADDR:      state_d = is_store_q ? ST_MEM_WR : ST_MEM_RD;
            ST_ADDI_EXEC: state_d = ST_ADDI_WB;
            ST_MEM_RD:    if (wait_done) state_d = ST_LW_WB;
            ST_MEM_WR:    if (wait_done) state_d = ST_FETCH;
            ST_R_WB, ST_ADDI_WB, ST_LW_WB,
            ST_BRANCH, ST_JUMP, ST_ILLEGAL: state_d = ST_FETCH;
            default:      state_d = ST_RESET;
        endcase

        // Counter restarts on every state change so each waiting state sees 0..MEM_WAIT
        if (state_d != state_q) begin
            wait_d = 3'd0;
        end else if (state_q == ST_FETCH || state_q == ST_MEM_RD || state_q == ST_MEM_WR) begin
            wait_d = wait_q + 3'd1;
        end else begin
            wait_d = 3'd0;
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCSRC_ALU;
        iord          = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mdr_load      = 1'b0;
        a_load        = 1'b0;
        b_load        = 1'b0;
        alu_out_load  = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALU_PASS_A;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        illegal_op    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                alu_src_b = SRCB_FOUR;
                alu_op    = ALU_ADD;
                if (wait_done) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    pc_source = PCSRC_ALU;
                end
            end
            ST_DECODE: begin
                alu_src_b    = SRCB_IMM_SH;
                alu_op       = ALU_ADD;
                alu_out_load = 1'b1;
                a_load       = 1'b1;
                b_load       = 1'b1;
            end
            ST_R_EXEC: begin
                alu_src_a    = 1'b1;
                alu_src_b    = SRCB_REG;
                alu_op       = r_op_q;
                alu_out_load = 1'b1;
            end
            ST_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            ST_ADDR, ST_ADDI_EXEC: begin
                alu_src_a    = 1'b1;
                alu_src_b    = SRCB_IMM;
                alu_op       = ALU_ADD;
                alu_out_load = 1'b1;
            end
            ST_ADDI_WB: reg_write = 1'b1;
            ST_MEM_RD: begin
                iord     = 1'b1;
                mdr_load = wait_done;
            end
            ST_LW_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_REG;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            ST_ILLEGAL: illegal_op = 1'b1;
            default: ;
        endcase
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl at MEM_WAIT 1 and 0
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       mdr_load;
        logic       a_load;
        logic       b_load;
        logic       alu_out_load;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal_op;
        logic [3:0] state;
    } outs_t;

    typedef struct {
        string tag;
        outs_t v;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h20;
    logic       alu_zero = 1'b0;

    logic       pw1, pwc1, iord1, mw1, irw1, mdr1, al1, bl1, aol1, sa1, rw1, rd1, m2r1, ill1;
    logic [1:0] pcs1, sb1;
    logic [2:0] aop1;
    logic [3:0] st1;
    logic       pw0, pwc0, iord0, mw0, irw0, mdr0, al0, bl0, aol0, sa0, rw0, rd0, m2r0, ill0;
    logic [1:0] pcs0, sb0;
    logic [2:0] aop0;
    logic [3:0] st0;

    int n_checks = 0;
    int n_err = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_WAIT(1)) dut1 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
        .pc_write(pw1), .pc_write_cond(pwc1), .pc_source(pcs1), .iord(iord1), .mem_write(mw1),
        .ir_write(irw1), .mdr_load(mdr1), .a_load(al1), .b_load(bl1), .alu_out_load(aol1),
        .alu_src_a(sa1), .alu_src_b(sb1), .alu_op(aop1), .reg_write(rw1), .reg_dst(rd1),
        .mem_to_reg(m2r1), .illegal_op(ill1), .state_dbg(st1)
    );

    multicycle_ctrl #(.MEM_WAIT(0)) dut0 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
        .pc_write(pw0), .pc_write_cond(pwc0), .pc_source(pcs0), .iord(iord0), .mem_write(mw0),
        .ir_write(irw0), .mdr_load(mdr0), .a_load(al0), .b_load(bl0), .alu_out_load(aol0),
        .alu_src_a(sa0), .alu_src_b(sb0), .alu_op(aop0), .reg_write(rw0), .reg_dst(rd0),
        .mem_to_reg(m2r0), .illegal_op(ill0), .state_dbg(st0)
    );

    outs_t obs1, obs0;
    assign obs1 = {pw1, pwc1, pcs1, iord1, mw1, irw1, mdr1, al1, bl1, aol1, sa1, sb1, aop1,
                   rw1, rd1, m2r1, ill1, st1};
    assign obs0 = {pw0, pwc0, pcs0, iord0, mw0, irw0, mdr0, al0, bl0, aol0, sa0, sb0, aop0,
                   rw0, rd0, m2r0, ill0, st0};

    function automatic outs_t exp_vec(input state_e st, input bit last, input logic [2:0] aop);
        outs_t v = '0;
        v.state = st;
        case (st)
            ST_FETCH: begin
                v.alu_src_b = 2'b01; v.alu_op = 3'b001;
                if (last) begin v.ir_write = 1'b1; v.pc_write = 1'b1; end
            end
            ST_DECODE: begin
                v.alu_src_b = 2'b11; v.alu_op = 3'b001;
                v.alu_out_load = 1'b1; v.a_load = 1'b1; v.b_load = 1'b1;
            end
            ST_R_EXEC: begin
                v.alu_src_a = 1'b1; v.alu_src_b = 2'b00; v.alu_op = aop; v.alu_out_load = 1'b1;
            end
            ST_R_WB:    begin v.reg_write = 1'b1; v.reg_dst = 1'b1; end
            ST_ADDR, ST_ADDI_EXEC: begin
                v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; v.alu_op = 3'b001; v.alu_out_load = 1'b1;
            end
            ST_ADDI_WB: v.reg_write = 1'b1;
            ST_MEM_RD:  begin v.iord = 1'b1; v.mdr_load = last; end
            ST_LW_WB:   begin v.reg_write = 1'b1; v.mem_to_reg = 1'b1; end
            ST_MEM_WR:  begin v.iord = 1'b1; v.mem_write = 1'b1; end
            ST_BRANCH: begin
                v.alu_src_a = 1'b1; v.alu_op = 3'b010; v.pc_write_cond = 1'b1; v.pc_source = 2'b01;
            end
            ST_JUMP:    begin v.pc_write = 1'b1; v.pc_source = 2'b10; end
            ST_ILLEGAL: v.illegal_op = 1'b1;
            default: ;
        endcase
        return v;
    endfunction

    task automatic push_state(input string tag, input state_e st, input bit last, input logic [2:0] aop);
        exp_t e;
        e.tag = {tag, ":", st.name()};
        e.v = exp_vec(st, last, aop);
        sbq.push_back(e);
    endtask

    task automatic push_instr(input string tag, input logic [5:0] op, input logic [5:0] fn, input int w);
        logic [2:0] aop;
        bit legal;
        legal = 1'b1;
        case (fn)
            6'h20: aop = 3'b001;
            6'h22: aop = 3'b010;
            6'h24: aop = 3'b011;
            6'h26: aop = 3'b110;
            default: begin aop = 3'b000; legal = 1'b0; end
        endcase
        for (int i = 0; i <= w; i++) push_state(tag, ST_FETCH, i == w, 3'b000);
        push_state(tag, ST_DECODE, 1'b0, 3'b000);
        case (op)
            6'h00: if (legal) begin
                push_state(tag, ST_R_EXEC, 1'b0, aop);
                push_state(tag, ST_R_WB, 1'b0, 3'b000);
            end else push_state(tag, ST_ILLEGAL, 1'b0, 3'b000);
            6'h08: begin
                push_state(tag, ST_ADDI_EXEC, 1'b0, 3'b000);
                push_state(tag, ST_ADDI_WB, 1'b0, 3'b000);
            end
            6'h23: begin
                push_state(tag, ST_ADDR, 1'b0, 3'b000);
                for (int i = 0; i <= w; i++) push_state(tag, ST_MEM_RD, i == w, 3'b000);
                push_state(tag, ST_LW_WB, 1'b0, 3'b000);
            end
            6'h2B: begin
                push_state(tag, ST_ADDR, 1'b0, 3'b000);
                for (int i = 0; i <= w; i++) push_state(tag, ST_MEM_WR, i == w, 3'b000);
            end
            6'h04: push_state(tag, ST_BRANCH, 1'b0, 3'b000);
            6'h02: push_state(tag, ST_JUMP, 1'b0, 3'b000);
            default: push_state(tag, ST_ILLEGAL, 1'b0, 3'b000);
        endcase
        opcode = op;
        funct  = fn;
    endtask

    task automatic check(input string tag, input outs_t got, input outs_t exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic run_sb(input bit use_w0);
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            @(posedge clk);
            #1;
            check(e.tag, use_w0 ? obs0 : obs1, e.v);
        end
    endtask

    initial begin
        reset = 1'b1;
        push_state("por", ST_RESET, 1'b0, 3'b000);
        push_state("por", ST_RESET, 1'b0, 3'b000);
        run_sb(1'b0);

        // Reset held three cycles in the middle of a FETCH wait
        reset = 1'b0;
        push_state("pre", ST_FETCH, 1'b0, 3'b000);
        run_sb(1'b0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) push_state("rst3", ST_RESET, 1'b0, 3'b000);
        run_sb(1'b0);
        reset = 1'b0;

        push_instr("add", 6'h00, 6'h20, 1); run_sb(1'b0);
        push_instr("sub", 6'h00, 6'h22, 1); run_sb(1'b0);
        push_instr("and", 6'h00, 6'h24, 1); run_sb(1'b0);
        push_instr("xor", 6'h00, 6'h26, 1); run_sb(1'b0);
        push_instr("addi", 6'h08, 6'h15, 1); run_sb(1'b0);
        push_instr("lw", 6'h23, 6'h00, 1); run_sb(1'b0);
        push_instr("sw", 6'h2B, 6'h3F, 1); run_sb(1'b0);
        alu_zero = 1'b1;
        push_instr("beq_z1", 6'h04, 6'h00, 1); run_sb(1'b0);
        alu_zero = 1'b0;
        push_instr("beq_z0", 6'h04, 6'h00, 1); run_sb(1'b0);
        push_instr("j", 6'h02, 6'h20, 1); run_sb(1'b0);
        push_instr("ill_op", 6'h3F, 6'h20, 1); run_sb(1'b0);
        push_instr("ill_fn", 6'h00, 6'h00, 1); run_sb(1'b0);
        push_instr("after_ill", 6'h08, 6'h00, 1); run_sb(1'b0);

        // sw aborted by reset during its first write cycle: no strobe afterwards
        opcode = 6'h2B;
        push_state("abort", ST_FETCH, 1'b0, 3'b000);
        push_state("abort", ST_FETCH, 1'b1, 3'b000);
        push_state("abort", ST_DECODE, 1'b0, 3'b000);
        push_state("abort", ST_ADDR, 1'b0, 3'b000);
        push_state("abort", ST_MEM_WR, 1'b0, 3'b000);
        run_sb(1'b0);
        reset = 1'b1;
        push_state("abort", ST_RESET, 1'b0, 3'b000);
        run_sb(1'b0);

        // Zero-wait instance
        push_state("w0rst", ST_RESET, 1'b0, 3'b000);
        run_sb(1'b1);
        reset = 1'b0;
        push_instr("w0_sw", 6'h2B, 6'h00, 0); run_sb(1'b1);
        push_instr("w0_add", 6'h00, 6'h20, 0); run_sb(1'b1);
        push_instr("w0_lw", 6'h23, 6'h00, 0); run_sb(1'b1);
        push_instr("w0_j", 6'h02, 6'h00, 0); run_sb(1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
